// File: rtl/walk_service_controller_pkg.sv
// ---------------------------------------------------------------------------
// walk_pkg
// Shared definitions for the pedestrian walk-service controller:
//   - 3-bit state encodings (IDLE/REQ/WALK/FLASH/DONE) and the state enum
//   - default WALK_TIME, FLASH_TIME and TIMER_W parameter values
// ---------------------------------------------------------------------------
package walk_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WALK  = 3'd2;
    localparam logic [2:0] ST_FLASH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int DEF_WALK_TIME  = 3;
    localparam int DEF_FLASH_TIME = 2;
    localparam int DEF_TIMER_W    = 4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        WALK  = ST_WALK,
        FLASH = ST_FLASH,
        DONE  = ST_DONE
    } walkState_t;

endpackage

// File: rtl/walk_service_controller_if.sv
// ---------------------------------------------------------------------------
// walk_service_controller_if
// Bundles the walk-service controller's request/grant/lamp signals.
//   slave  : the controller's view (walk_status, tick, walk_grant in;
//            walk_req, walk_done, walk_clear, walk_lamp, dont_walk_lamp out)
//   master : the surrounding system's view (directions reversed)
// ---------------------------------------------------------------------------
interface walk_service_controller_if;

    logic walk_status;
    logic tick;
    logic walk_grant;
    logic walk_req;
    logic walk_done;
    logic walk_clear;
    logic walk_lamp;
    logic dont_walk_lamp;

    modport slave (
        input  walk_status,
        input  tick,
        input  walk_grant,
        output walk_req,
        output walk_done,
        output walk_clear,
        output walk_lamp,
        output dont_walk_lamp
    );

    modport master (
        output walk_status,
        output tick,
        output walk_grant,
        input  walk_req,
        input  walk_done,
        input  walk_clear,
        input  walk_lamp,
        input  dont_walk_lamp
    );

endinterface

// File: rtl/walk_service_controller_timer.sv
// ---------------------------------------------------------------------------
// walk_timer
// TIMER_W-bit tick down-counter used to time the WALK and FLASH phases.
//   clk        : system clock
//   sys_reset  : synchronous active-high reset (count -> 0)
//   load       : load load_value (takes priority over tick)
//   load_value : value to load
//   tick       : decrement enable
//   last       : tick arriving while the count is 1
// ---------------------------------------------------------------------------
module walk_timer
    import walk_pkg::*;
#(
    parameter int TIMER_W = DEF_TIMER_W
) (
    input  logic               clk,
    input  logic               sys_reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               tick,
    output logic               last
);

    logic [TIMER_W-1:0] count;

    // Count saturates at zero so stray ticks can never wrap it around.
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = tick && (count == TIMER_W'(1));

endmodule

// File: rtl/walk_service_controller.sv
// ---------------------------------------------------------------------------
// walk_service_controller
// Services latched pedestrian requests: asks the main traffic FSM for a
// crossing window, lights WALK for WALK_TIME ticks, flashes DON'T WALK for
// FLASH_TIME ticks, then reports walk_done. walk_clear pulses once in the
// first WALK cycle of each crossing. All outputs are registered.
//   clk       : system clock
//   sys_reset : synchronous active-high reset
//   bus       : walk_service_controller_if.slave (status/tick/grant in,
//               req/done/clear/lamps out)
// Optional feature macro: WALK_PREEMPT_EN -- when defined, walk_grant
// falling during WALK cuts straight to the FLASH clearance interval.
// ---------------------------------------------------------------------------
module walk_service_controller
    import walk_pkg::*;
#(
    parameter int WALK_TIME  = DEF_WALK_TIME,
    parameter int FLASH_TIME = DEF_FLASH_TIME,
    parameter int TIMER_W    = DEF_TIMER_W
) (
    input  logic                      clk,
    input  logic                      sys_reset,
    walk_service_controller_if.slave  bus
);

    walkState_t         state;
    walkState_t         nextState;
    logic               flashPhase;
    logic               nextFlashPhase;
    logic               timerLoad;
    logic [TIMER_W-1:0] timerLoadValue;
    logic               timerTick;
    logic               timerLast;

    logic nextReq;
    logic nextDone;
    logic nextClear;
    logic nextWalkLamp;
    logic nextDontWalkLamp;

    // Ticks only matter while a crossing is being timed.
    assign timerTick = bus.tick && ((state == WALK) || (state == FLASH));

    walk_timer #(
        .TIMER_W (TIMER_W)
    ) uTimer (
        .clk        (clk),
        .sys_reset  (sys_reset),
        .load       (timerLoad),
        .load_value (timerLoadValue),
        .tick       (timerTick),
        .last       (timerLast)
    );

    // State, flash phase and all outputs are registered together so the
    // outputs always describe the state currently held.
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state              <= IDLE;
            flashPhase         <= 1'b0;
            bus.walk_req       <= 1'b0;
            bus.walk_done      <= 1'b0;
            bus.walk_clear     <= 1'b0;
            bus.walk_lamp      <= 1'b0;
            bus.dont_walk_lamp <= 1'b1;
        end else begin
            state              <= nextState;
            flashPhase         <= nextFlashPhase;
            bus.walk_req       <= nextReq;
            bus.walk_done      <= nextDone;
            bus.walk_clear     <= nextClear;
            bus.walk_lamp      <= nextWalkLamp;
            bus.dont_walk_lamp <= nextDontWalkLamp;
        end
    end

    // Next-state logic plus decode of the next registered output values.
    // The grant edge in REQ loads the timer, so a tick in that same cycle
    // is lost; the first tick that counts is the one in the WALK entry cycle.
    always_comb begin
        nextState      = state;
        nextFlashPhase = flashPhase;
        timerLoad      = 1'b0;
        timerLoadValue = '0;

        case (state)
            IDLE: begin
                if (bus.walk_status) begin
                    nextState = REQ;
                end
            end
            REQ: begin
                if (bus.walk_grant) begin
                    nextState      = WALK;
                    timerLoad      = 1'b1;
                    timerLoadValue = TIMER_W'(WALK_TIME);
                end
            end
            WALK: begin
`ifdef WALK_PREEMPT_EN
                if (timerLast || !bus.walk_grant) begin
`else
                if (timerLast) begin
`endif
                    nextState      = FLASH;
                    timerLoad      = 1'b1;
                    timerLoadValue = TIMER_W'(FLASH_TIME);
                    nextFlashPhase = 1'b1;
                end
            end
            FLASH: begin
                if (timerTick) begin
                    nextFlashPhase = ~flashPhase;
                end
                if (timerLast) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        nextReq          = (nextState == REQ);
        nextDone         = (nextState == DONE);
        nextClear        = (nextState == WALK) && (state != WALK);
        nextWalkLamp     = (nextState == WALK);
        nextDontWalkLamp = (nextState == FLASH) ? nextFlashPhase
                                                : (nextState != WALK);
    end

endmodule
